seq_multiplier: RTL and testbench

Parametrised iterative shift-add multiplier. Successor to the fixed 12-bit multiplier, generalised in width, with signed/unsigned mode per operation and valid/ready handshakes on input and output. It sits between an operand producer and a result consumer in the arithmetic datapath. It trades latency (about WIDTH+1 cycles) for a single adder.

---
 rtl/seq_multiplier.sv | 121 ++++++++++++
 tb/tb_seq_multiplier.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned per operation.
// Optional build macro SEQ_MULT_EARLY_EXIT_EN ends CALC as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   c_q, c_d;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       upper;
  logic [2*WIDTH:0]     acc_shift;
  logic [WIDTH-1:0]     mplier_shift;
  logic [CW-1:0]        cnt_inc;

  // Magnitudes stay unsigned in WIDTH bits, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
  assign a_abs = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_abs = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  assign upper        = mplier_q[0] ? (acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q}) : acc_q[2*WIDTH:WIDTH];
  assign acc_shift    = {upper, acc_q[WIDTH-1:0]} >> 1;
  assign mplier_shift = mplier_q >> 1;
  assign cnt_inc      = cnt_q + CW'(1);

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can leave it unassigned (no latches).
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    c_d      = c_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_abs;
          mplier_d = b_abs;
          sign_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_shift;
        mplier_d = mplier_shift;
        cnt_d    = cnt_inc;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
`ifdef SEQ_MULT_EARLY_EXIT_EN
        else if (mplier_shift == '0) begin
          // Apply the right shifts the skipped iterations would have performed.
          acc_d   = acc_shift >> (CW'(WIDTH) - cnt_inc);
          state_d = FIX;
        end
`endif
      end
      FIX: begin
        c_d     = sign_q ? (~acc_q[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_q[2*WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      c_q      <= c_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c         = c_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=12 (either build of SEQ_MULT_EARLY_EXIT_EN).
module tb_seq_multiplier;

  localparam int W = 12;

  logic           clk, rst, in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] c;

  int total = 0;
  int bad   = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edges from accept to first out_valid: WIDTH+1, or iterations+1 with early exit.
  function automatic int exp_latency(input logic [W-1:0] bv, input logic s);
    logic [W-1:0] mag;
    int iters;
    bit ee_build;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    ee_build = 1'b1;
`else
    ee_build = 1'b0;
`endif
    mag = (s && bv[W-1]) ? (~bv + W'(1)) : bv;
    iters = 1;
    for (int i = 0; i < W; i++) if (mag[i]) iters = i + 1;
    return ee_build ? iters + 1 : W + 1;
  endfunction

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input logic hold);
    a = av; b = bv; is_signed = s; in_valid = 1'b1;
    check("in_ready_pre_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    if (!hold) begin
      in_valid = 1'b0; a = ~av; b = ~bv; is_signed = ~s;
    end
    check("busy_post_accept", busy, 1'b1);
    check("in_ready_post_accept", in_ready, 1'b0);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic handshake(input string tag, input logic [2*W-1:0] exp_c);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_c_hold"}, c, exp_c);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic s, input logic [2*W-1:0] exp_c);
    accept(av, bv, s, 1'b0);
    wait_result(tag, exp_latency(bv, s));
    check({tag, "_c"}, c, exp_c);
    handshake(tag, exp_c);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; a = 12'hFFF; b = 12'hFFF; is_signed = 1'b0; out_ready = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_c", c, 24'h0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", busy, 1'b0);

    run_op("u_fff_fff", 12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);

    // Back-to-back: second pair presented during the first op, accepted only after its handshake.
    accept(12'h124, 12'h321, 1'b0, 1'b1);
    a = 12'h008; b = 12'h002; is_signed = 1'b0;
    wait_result("b2b_1", exp_latency(12'h321, 1'b0));
    check("b2b_1_c", c, 24'h0391A4);
    check("b2b_1_in_ready_busy", in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_1_ov_drop", out_valid, 1'b0);
    check("b2b_1_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_2_busy", busy, 1'b1);
    wait_result("b2b_2", exp_latency(12'h002, 1'b0));
    check("b2b_2_c", c, 24'h000010);
    handshake("b2b_2", 24'h000010);

    run_op("s_m1_m1",    12'hFFF, 12'hFFF, 1'b1, 24'h000001);
    run_op("s_min_min",  12'h800, 12'h800, 1'b1, 24'h400000);
    run_op("s_min_one",  12'h800, 12'h001, 1'b1, 24'hFFF800);
    run_op("s_zero_min", 12'h000, 12'h800, 1'b1, 24'h000000);
    run_op("s_min_zero", 12'h800, 12'h000, 1'b1, 24'h000000);
    run_op("s_3_m2",     12'h003, 12'hFFE, 1'b1, 24'hFFFFFA);
    run_op("u_min_min",  12'h800, 12'h800, 1'b0, 24'h400000);
    run_op("u_321_002",  12'h321, 12'h002, 1'b0, 24'h000642);
    run_op("u_5a5_000",  12'h5A5, 12'h000, 1'b0, 24'h000000);

    // Result must not follow operand changes once the block is idle.
    a = 12'h123; b = 12'h456; is_signed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("c_idle_hold", c, 24'h000000);

    // Backpressure in DONE.
    accept(12'h7FF, 12'h800, 1'b1, 1'b0);
    wait_result("bp", exp_latency(12'h800, 1'b1));
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_c", c, 24'hC00800);
      check("bp_in_ready", in_ready, 1'b0);
    end
    handshake("bp", 24'hC00800);

    // Reset in the middle of CALC with the iteration counter at 5.
    accept(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_c", c, 24'h0);
    check("midrst_in_ready", in_ready, 1'b1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_spurious", seen, 0);

    run_op("post_rst", 12'h124, 12'h321, 1'b1, 24'h0391A4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
